rv32i_mc_ctl: RTL and testbench

Multi-cycle sequencing controller for the RV32I core.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives register enables, mux selects and memory requests.
- Drives the 2-bit alu_op consumed by the ALU control decoder.
- Sits between the IR/opcode decoder and the single shared ALU, register file and memory port.
- One instruction in flight; no pipelining.

---
 rtl/rv32i_mc_ctl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_rv32i_mc_ctl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_ctl.sv
// ---------------------------------------------------------------------------
// rv32i_mc_ctl
// Multi-cycle sequencing controller for the RV32I core. Steps one instruction
// at a time through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). It drives the
// register enables, mux selects and memory requests for a datapath with a
// single shared ALU, register file and memory port.
//
// Parameters:
//   RESET_PC     PC value presented on o_reset_pc (loaded while i_rst is high)
//   MEM_TIMEOUT  max request cycles without i_mem_ready before trapping;
//                0 disables the timeout
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_opcode          IR[6:0], valid from DECODE onward
//   i_branch_taken    branch comparator result, used in EXEC
//   i_mem_ready       memory handshake (accepted / data valid this cycle)
//   o_state           current FSM state (debug)
//   o_imem_req        instruction fetch request
//   o_dmem_req        data access request; o_dmem_we marks a store
//   o_ir_we, o_pc_we  IR latch and PC update enables
//   o_pc_sel          0 = PC+4, 1 = ALU result
//   o_rf_we           register file write
//   o_alu_op          00 R-type, 01 I-type, 10 pass B, 11 forced ADD
//   o_alu_src_a/b     operand selects (a: 0 rs1 / 1 PC, b: 0 rs2 / 1 imm)
//   o_wb_sel          00 ALU, 01 memory, 10 PC+4
//   o_retire          one-cycle pulse when an instruction completes
//   o_trap            high while in TRAP (illegal opcode / memory timeout)
//   o_reset_pc        RESET_PC constant
//
// Optional feature macro: RV32I_MC_CTL_PERF_CNT_EN
//   When defined, adds o_cycle_cnt and o_instret_cnt performance counters.
// ---------------------------------------------------------------------------
module rv32i_mc_ctl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [6:0]  i_opcode,
    input  logic        i_branch_taken,
    input  logic        i_mem_ready,
    output logic [2:0]  o_state,
    output logic        o_imem_req,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_ir_we,
    output logic        o_pc_we,
    output logic        o_pc_sel,
    output logic        o_rf_we,
    output logic [1:0]  o_alu_op,
    output logic        o_alu_src_a,
    output logic        o_alu_src_b,
    output logic [1:0]  o_wb_sel,
    output logic        o_retire,
    output logic        o_trap,
    output logic [31:0] o_reset_pc
`ifdef RV32I_MC_CTL_PERF_CNT_EN
    ,
    output logic [31:0] o_cycle_cnt,
    output logic [31:0] o_instret_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
    } op_class_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    op_class_t   op_class;
    logic [15:0] timeout_cnt;
    logic        waiting;
    logic        timed_out;

    assign o_reset_pc = RESET_PC;

    // Opcode classification; the opcode is held stable in IR from DECODE on,
    // so the class is recomputed every cycle instead of being registered.
    always_comb begin
        case (i_opcode)
            7'b0110011: op_class = CL_R;
            7'b0010011: op_class = CL_I;
            7'b0000011: op_class = CL_LOAD;
            7'b0100011: op_class = CL_STORE;
            7'b1100011: op_class = CL_BRANCH;
            7'b1101111: op_class = CL_JAL;
            7'b1100111: op_class = CL_JALR;
            7'b0110111: op_class = CL_LUI;
            7'b0010111: op_class = CL_AUIPC;
            default:    op_class = CL_ILLEGAL;
        endcase
    end

    // A memory wait is a requesting state without ready. The timeout fires on
    // the last permitted wait cycle; a ready on that same cycle wins because
    // waiting is then low.
    assign waiting   = ((state == FETCH) || (state == MEM)) && !i_mem_ready;
    assign timed_out = (MEM_TIMEOUT != 0) && waiting && (timeout_cnt == TIMEOUT_LAST);

    // Next-state selection.
    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (i_mem_ready)
                    next_state = DECODE;
                else if (timed_out)
                    next_state = TRAP;
            end
            DECODE: begin
                next_state = (op_class == CL_ILLEGAL) ? TRAP : EXEC;
            end
            EXEC: begin
                case (op_class)
                    CL_LOAD, CL_STORE: next_state = MEM;
                    CL_BRANCH:         next_state = FETCH;
                    CL_ILLEGAL:        next_state = TRAP;
                    default:           next_state = WB;
                endcase
            end
            MEM: begin
                if (i_mem_ready)
                    next_state = (op_class == CL_STORE) ? FETCH : WB;
                else if (timed_out)
                    next_state = TRAP;
            end
            WB:      next_state = FETCH;
            TRAP:    next_state = TRAP;
            default: next_state = TRAP;
        endcase
    end

    // State register and wait counter. The counter only runs while a request
    // is stalled and is cleared by ready, by leaving the state, or by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= FETCH;
            timeout_cnt <= 16'd0;
        end else begin
            state <= next_state;
            if (waiting && (next_state == state))
                timeout_cnt <= timeout_cnt + 16'd1;
            else
                timeout_cnt <= 16'd0;
        end
    end

    // Output decode. Everything is forced to its idle value while reset is
    // high so that an instruction aborted by reset has no side effects.
    always_comb begin
        o_state     = i_rst ? FETCH : state;
        o_imem_req  = 1'b0;
        o_dmem_req  = 1'b0;
        o_dmem_we   = 1'b0;
        o_ir_we     = 1'b0;
        o_pc_we     = 1'b0;
        o_pc_sel    = 1'b0;
        o_rf_we     = 1'b0;
        o_alu_op    = 2'b00;
        o_alu_src_a = 1'b0;
        o_alu_src_b = 1'b0;
        o_wb_sel    = 2'b00;
        o_retire    = 1'b0;
        o_trap      = 1'b0;
        if (!i_rst) begin
            case (state)
                FETCH: begin
                    o_imem_req = 1'b1;
                    o_ir_we    = i_mem_ready;
                end
                EXEC: begin
                    case (op_class)
                        CL_R: begin
                            o_alu_op = 2'b00;
                        end
                        CL_I: begin
                            o_alu_op    = 2'b01;
                            o_alu_src_b = 1'b1;
                        end
                        CL_LUI: begin
                            o_alu_op    = 2'b10;
                            o_alu_src_b = 1'b1;
                        end
                        CL_AUIPC, CL_JAL: begin
                            o_alu_op    = 2'b11;
                            o_alu_src_a = 1'b1;
                            o_alu_src_b = 1'b1;
                        end
                        CL_LOAD, CL_STORE, CL_JALR: begin
                            o_alu_op    = 2'b11;
                            o_alu_src_b = 1'b1;
                        end
                        CL_BRANCH: begin
                            o_alu_op    = 2'b11;
                            o_alu_src_a = 1'b1;
                            o_alu_src_b = 1'b1;
                            o_pc_we     = 1'b1;
                            o_pc_sel    = i_branch_taken;
                            o_retire    = 1'b1;
                        end
                        default: begin
                            o_alu_op = 2'b00;
                        end
                    endcase
                end
                MEM: begin
                    o_dmem_req = 1'b1;
                    o_dmem_we  = (op_class == CL_STORE);
                    if (i_mem_ready && (op_class == CL_STORE)) begin
                        o_pc_we  = 1'b1;
                        o_retire = 1'b1;
                    end
                end
                WB: begin
                    o_rf_we  = 1'b1;
                    o_pc_we  = 1'b1;
                    o_retire = 1'b1;
                    if (op_class == CL_LOAD) begin
                        o_wb_sel = 2'b01;
                    end else if ((op_class == CL_JAL) || (op_class == CL_JALR)) begin
                        o_wb_sel = 2'b10;
                        o_pc_sel = 1'b1;
                    end
                end
                TRAP: begin
                    o_trap = 1'b1;
                end
                default: begin
                    o_trap = 1'b0;
                end
            endcase
        end
    end

`ifdef RV32I_MC_CTL_PERF_CNT_EN
    // Free-running cycle and retired-instruction counters, wrapping at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cycle_cnt   <= 32'd0;
            o_instret_cnt <= 32'd0;
        end else begin
            o_cycle_cnt <= o_cycle_cnt + 32'd1;
            if (o_retire)
                o_instret_cnt <= o_instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_mc_ctl.sv
// ---------------------------------------------------------------------------
// tb_rv32i_mc_ctl
// Self-checking bench for rv32i_mc_ctl. A per-instruction model expands each
// directed instruction (opcode, branch outcome, memory wait counts) into the
// cycle-by-cycle inputs and the outputs the controller must show, and a
// compare process checks every cycle against that expansion.
// ---------------------------------------------------------------------------
module tb_rv32i_mc_ctl;

    localparam int TIMEOUT = 16;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic       pc_sel;
        logic       rf_we;
        logic [1:0] alu_op;
        logic       src_a;
        logic       src_b;
        logic [1:0] wb_sel;
        logic       retire;
        logic       trap;
    } outs_t;

    typedef struct packed {
        logic       rst;
        logic [6:0] opc;
        logic       taken;
        logic       ready;
        outs_t      exp;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        taken = 1'b0;
    logic        ready = 1'b0;
    logic [2:0]  o_state;
    logic        o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_pc_we, o_pc_sel;
    logic        o_rf_we, o_alu_src_a, o_alu_src_b, o_retire, o_trap;
    logic [1:0]  o_alu_op, o_wb_sel;
    logic [31:0] o_reset_pc;

    cyc_t  sched[$];
    cyc_t  cur;
    int    cur_idx = 0;
    bit    cur_valid = 1'b0;
    int    compared = 0;
    int    mismatched = 0;
    int    retire_seen = 0;
    outs_t actual;

    always #5 clk = ~clk;

    rv32i_mc_ctl #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(TIMEOUT)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_opcode      (opcode),
        .i_branch_taken(taken),
        .i_mem_ready   (ready),
        .o_state       (o_state),
        .o_imem_req    (o_imem_req),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_ir_we       (o_ir_we),
        .o_pc_we       (o_pc_we),
        .o_pc_sel      (o_pc_sel),
        .o_rf_we       (o_rf_we),
        .o_alu_op      (o_alu_op),
        .o_alu_src_a   (o_alu_src_a),
        .o_alu_src_b   (o_alu_src_b),
        .o_wb_sel      (o_wb_sel),
        .o_retire      (o_retire),
        .o_trap        (o_trap),
        .o_reset_pc    (o_reset_pc)
    );

    assign actual = {o_state, o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_pc_we,
                     o_pc_sel, o_rf_we, o_alu_op, o_alu_src_a, o_alu_src_b,
                     o_wb_sel, o_retire, o_trap};

    // Generic comparison; X/Z on the DUT side counts as a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic outs_t blank(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.state = st;
        return o;
    endfunction

    task automatic push(input logic r, input logic [6:0] opc, input logic tk,
                        input logic rdy, input outs_t e);
        cyc_t c;
        c.rst   = r;
        c.opc   = opc;
        c.taken = tk;
        c.ready = rdy;
        c.exp   = e;
        sched.push_back(c);
    endtask

    task automatic applyReset(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 7'd0, 1'b0, 1'b1, blank(3'd0));
    endtask

    task automatic pushTrap(input logic [6:0] opc, input int n);
        outs_t e;
        e = blank(3'd7);
        e.trap = 1'b1;
        for (int i = 0; i < n; i++) push(1'b0, opc, 1'b0, 1'b1, e);
    endtask

    // Model of one instruction. fetch_wait/mem_wait are the stalled cycles
    // before ready; abort_at >= 0 asserts reset on that MEM wait cycle.
    task automatic applyStimulus(input logic [6:0] op, input logic tk, input int fetch_wait,
                                 input int mem_wait, input int abort_at, output int ncyc);
        outs_t e;
        int    start;
        bit    is_mem;
        bit    legal;
        start  = sched.size();
        is_mem = (op == OP_LOAD) || (op == OP_STORE);
        legal  = (op == OP_R) || (op == OP_I) || is_mem || (op == OP_BRANCH) ||
                 (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
        ncyc = 0;

        for (int i = 0; i < fetch_wait && i < TIMEOUT; i++) begin
            e = blank(3'd0);
            e.imem_req = 1'b1;
            push(1'b0, op, tk, 1'b0, e);
        end
        if (fetch_wait >= TIMEOUT) begin
            pushTrap(op, 3);
            ncyc = sched.size() - start;
            return;
        end
        e = blank(3'd0);
        e.imem_req = 1'b1;
        e.ir_we    = 1'b1;
        push(1'b0, op, tk, 1'b1, e);

        push(1'b0, op, tk, 1'b1, blank(3'd1));
        if (!legal) begin
            pushTrap(op, 3);
            ncyc = sched.size() - start;
            return;
        end

        e = blank(3'd2);
        e.alu_op = 2'b11;
        e.src_b  = 1'b1;
        if (op == OP_R) begin
            e.alu_op = 2'b00;
            e.src_b  = 1'b0;
        end else if (op == OP_I) begin
            e.alu_op = 2'b01;
        end else if (op == OP_LUI) begin
            e.alu_op = 2'b10;
        end
        if (op == OP_AUIPC || op == OP_JAL || op == OP_BRANCH) e.src_a = 1'b1;
        if (op == OP_BRANCH) begin
            e.pc_we  = 1'b1;
            e.pc_sel = tk;
            e.retire = 1'b1;
        end
        push(1'b0, op, tk, 1'b1, e);
        if (op == OP_BRANCH) begin
            ncyc = sched.size() - start;
            return;
        end

        if (is_mem) begin
            for (int i = 0; i < mem_wait && i < TIMEOUT; i++) begin
                if (i == abort_at) begin
                    applyReset(1);
                    ncyc = sched.size() - start;
                    return;
                end
                e = blank(3'd3);
                e.dmem_req = 1'b1;
                e.dmem_we  = (op == OP_STORE);
                push(1'b0, op, tk, 1'b0, e);
            end
            if (mem_wait >= TIMEOUT) begin
                pushTrap(op, 3);
                ncyc = sched.size() - start;
                return;
            end
            e = blank(3'd3);
            e.dmem_req = 1'b1;
            e.dmem_we  = (op == OP_STORE);
            if (op == OP_STORE) begin
                e.pc_we  = 1'b1;
                e.retire = 1'b1;
            end
            push(1'b0, op, tk, 1'b1, e);
            if (op == OP_STORE) begin
                ncyc = sched.size() - start;
                return;
            end
        end

        e = blank(3'd4);
        e.rf_we  = 1'b1;
        e.pc_we  = 1'b1;
        e.retire = 1'b1;
        if (op == OP_LOAD) e.wb_sel = 2'b01;
        if (op == OP_JAL || op == OP_JALR) begin
            e.wb_sel = 2'b10;
            e.pc_sel = 1'b1;
        end
        push(1'b0, op, tk, 1'b1, e);
        ncyc = sched.size() - start;
    endtask

    // Compare process: outputs are combinational, so they are checked on the
    // falling edge after the inputs for the cycle have settled.
    always @(negedge clk) begin
        if (cur_valid)
            checkOutput($sformatf("cycle%0d_op%b", cur_idx, cur.opc),
                        32'(actual), 32'(cur.exp));
    end

    always @(posedge clk) begin
        if (cur_valid && o_retire === 1'b1) retire_seen++;
    end

    initial begin
        int n;
        applyReset(2);
        applyStimulus(OP_R, 1'b0, 0, 0, -1, n);
        checkOutput("len_add", 32'(n), 32'd4);
        applyStimulus(OP_LOAD, 1'b0, 0, 3, -1, n);
        checkOutput("len_load_wait3", 32'(n), 32'd8);
        applyStimulus(OP_BRANCH, 1'b1, 0, 0, -1, n);
        checkOutput("len_branch_taken", 32'(n), 32'd3);
        applyStimulus(OP_BRANCH, 1'b0, 0, 0, -1, n);
        checkOutput("len_branch_not", 32'(n), 32'd3);
        applyStimulus(OP_STORE, 1'b0, 0, 0, -1, n);
        checkOutput("len_store", 32'(n), 32'd4);
        applyStimulus(OP_JAL, 1'b0, 0, 0, -1, n);
        applyStimulus(OP_JALR, 1'b0, 0, 0, -1, n);
        applyStimulus(OP_LUI, 1'b0, 0, 0, -1, n);
        applyStimulus(OP_AUIPC, 1'b0, 0, 0, -1, n);
        applyStimulus(OP_LOAD, 1'b0, 0, 0, -1, n);
        checkOutput("len_load", 32'(n), 32'd5);
        applyStimulus(OP_I, 1'b0, 2, 0, -1, n);
        applyStimulus(OP_BAD, 1'b0, 0, 0, -1, n);
        applyReset(1);
        applyStimulus(OP_R, 1'b0, 20, 0, -1, n);
        checkOutput("len_fetch_timeout", 32'(n), 32'd19);
        applyReset(1);
        applyStimulus(OP_R, 1'b0, 15, 0, -1, n);
        checkOutput("len_ready_on_16", 32'(n), 32'd19);
        applyStimulus(OP_STORE, 1'b0, 0, 5, 2, n);
        applyStimulus(OP_R, 1'b0, 0, 0, -1, n);

        rst = 1'b1;
        for (int i = 0; i < sched.size(); i++) begin
            @(posedge clk);
            #1;
            cur     = sched[i];
            cur_idx = i;
            rst     = sched[i].rst;
            opcode  = sched[i].opc;
            taken   = sched[i].taken;
            ready   = sched[i].ready;
            cur_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;
        checkOutput("retire_total", 32'(retire_seen), 32'd13);
        checkOutput("reset_pc", o_reset_pc, 32'h0000_0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
